// File: rtl/i2s_rx_oversampled_if.sv
// i2s_rx_oversampled_if: read-side bus between the I2S capture FIFO and its consumer
interface i2s_rx_oversampled_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  logic                          adcfifo_read;
  logic                          adcfifo_empty;
  logic [DATA_WIDTH-1:0]         adcfifo_readdata;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          overflow;
  modport master (input adcfifo_read, output adcfifo_empty, adcfifo_readdata, fifo_level, overflow);
  modport slave (output adcfifo_read, input adcfifo_empty, adcfifo_readdata, fifo_level, overflow);
endinterface

// File: rtl/i2s_rx_oversampled.sv
// i2s_rx_oversampled: oversampled I2S receiver packing left/right samples into a small word FIFO
module i2s_rx_oversampled #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bclk,
  input  logic adclrc,
  input  logic adcdat,
  i2s_rx_oversampled_if.master fifo
);
  localparam int CH_W = DATA_WIDTH / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(CH_W + 1);
  logic [SYNC_STAGES-1:0] bclk_s, lrc_s, dat_s;
  logic bclk_d, rise, lrc, dat, lrc_last, ch, left_ok, push;
  logic [CW-1:0] bit_cnt;
  logic [CH_W-1:0] shift, shift_nxt, left_hold;
  logic [DATA_WIDTH-1:0] push_word;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic full, wr, rd;
  assign lrc       = lrc_s[SYNC_STAGES-1];
  assign dat       = dat_s[SYNC_STAGES-1];
  assign rise      = bclk_s[SYNC_STAGES-1] & ~bclk_d;
  assign shift_nxt = {shift[CH_W-2:0], dat};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bclk_s <= '0;
      lrc_s  <= '0;
      dat_s  <= '0;
      bclk_d <= 1'b0;
    end else begin
      bclk_s <= {bclk_s[SYNC_STAGES-2:0], bclk};
      lrc_s  <= {lrc_s[SYNC_STAGES-2:0], adclrc};
      dat_s  <= {dat_s[SYNC_STAGES-2:0], adcdat};
      bclk_d <= bclk_s[SYNC_STAGES-1];
    end
  // bit_cnt parks at CH_W so nothing is captured until the first LRC transition
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lrc_last  <= 1'b0;
      ch        <= 1'b0;
      left_ok   <= 1'b0;
      push      <= 1'b0;
      bit_cnt   <= CW'(CH_W);
      shift     <= '0;
      left_hold <= '0;
      push_word <= '0;
    end else begin
      push <= 1'b0;
      if (rise) begin
        lrc_last <= lrc;
        if (lrc != lrc_last) begin
          bit_cnt <= '0;
          ch      <= lrc;
          shift   <= '0;
          if (!ch && bit_cnt < CW'(CH_W)) left_ok <= 1'b0;
        end else if (bit_cnt < CW'(CH_W)) begin
          shift   <= shift_nxt;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == CW'(CH_W - 1)) begin
            if (!ch) begin
              left_hold <= shift_nxt;
              left_ok   <= 1'b1;
            end else if (left_ok) begin
              push      <= 1'b1;
              push_word <= {left_hold, shift_nxt};
              left_ok   <= 1'b0;
            end
          end
        end
      end
    end
  assign full     = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign wr       = push & ~full;
  assign rd       = fifo.adcfifo_read & ~fifo.adcfifo_empty;
  assign wptr_nxt = wptr + {{AW{1'b0}}, wr};
  assign rptr_nxt = rptr + {{AW{1'b0}}, rd};
  always_ff @(posedge clk)
    if (wr) mem[wptr[AW-1:0]] <= push_word;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr                  <= '0;
      rptr                  <= '0;
      fifo.adcfifo_empty    <= 1'b1;
      fifo.adcfifo_readdata <= '0;
      fifo.fifo_level       <= '0;
      fifo.overflow         <= 1'b0;
    end else begin
      wptr               <= wptr_nxt;
      rptr               <= rptr_nxt;
      fifo.adcfifo_empty <= wptr_nxt == rptr_nxt;
      fifo.fifo_level    <= wptr_nxt - rptr_nxt;
      fifo.overflow      <= fifo.overflow | (push & full);
      if (rd) fifo.adcfifo_readdata <= mem[rptr[AW-1:0]];
    end
endmodule

// File: tb/tb_i2s_rx_oversampled.sv
// tb_i2s_rx_oversampled: codec-driven random/directed bench with a slot-level reference model
module tb_i2s_rx_oversampled;
  localparam int DW = 32, CH = 16, DEPTH = 4, SYNC = 2;
  logic clk = 0, reset_n = 0, bclk = 0, adclrc = 0, adcdat = 0;
  int n_chk = 0, n_err = 0, lo = 8, hi = 8;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd = '0, w;
  logic [CH-1:0] m_left = '0;
  logic movf = 0, m_lok = 0, m_last = 0;
  bit quiet = 0;

  i2s_rx_oversampled_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();
  i2s_rx_oversampled #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .adclrc(adclrc), .adcdat(adcdat), .fifo(bus)
  );

  always #10 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n) begin
      chk("readdata", bus.adcfifo_readdata, exp_rd);
      if (quiet) begin
        chk("level", bus.fifo_level, q.size());
        chk("empty", bus.adcfifo_empty, q.size() == 0);
        chk("overflow", bus.overflow, movf);
      end
    end

  task automatic rst_model;
    q.delete();
    exp_rd = '0;
    movf   = 0;
    m_lok  = 0;
    m_last = 0;
  endtask

  task automatic mpush(logic [DW-1:0] wd);
    if (q.size() == DEPTH) movf = 1;
    else q.push_back(wd);
  endtask

  task automatic bit_(logic l, logic d);
    @(negedge clk);
    bclk = 0; adclrc = l; adcdat = d;
    repeat (lo - 1) @(negedge clk);
    @(negedge clk);
    bclk = 1;
    repeat (hi - 1) @(negedge clk);
  endtask

  // one slot: a delay bit, then n data bits MSB first; only the first CH bits count
  task automatic slot(logic l, int n, logic [63:0] v);
    logic [CH-1:0] cap;
    quiet = 0;
    bit_(l, 1'($urandom));
    for (int i = n - 1; i >= 0; i--) bit_(l, v[i]);
    cap = (n >= CH) ? CH'(v >> (n - CH)) : '0;
    if (l != m_last) begin
      if (n >= CH) begin
        if (!l) begin
          m_left = cap;
          m_lok  = 1;
        end else if (m_lok) begin
          mpush({m_left, cap});
          m_lok = 0;
        end
      end else if (!l) m_lok = 0;
    end
    m_last = l;
  endtask

  task automatic frame(logic [63:0] l, logic [63:0] r, int n);
    slot(0, n, l);
    slot(1, n, r);
  endtask

  task automatic settle;
    repeat (SYNC + 12) @(negedge clk);
    quiet = 1;
  endtask

  task automatic rd(output logic [DW-1:0] wd);
    @(negedge clk);
    bus.adcfifo_read = 1;
    @(posedge clk);
    #1 bus.adcfifo_read = 0;
    if (q.size() > 0) exp_rd = q.pop_front();
    wd = exp_rd;
  endtask

  task automatic rd_lit(string nm, logic [DW-1:0] lit);
    logic [DW-1:0] wd;
    rd(wd);
    chk({nm, "_model"}, wd, lit);
    @(negedge clk);
    chk(nm, bus.adcfifo_readdata, lit);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.adcfifo_read = 0;
    repeat (10) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst_empty", bus.adcfifo_empty, 1);
    chk("rst_data", bus.adcfifo_readdata, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_ovf", bus.overflow, 0);
    quiet = 1;
    rd(w);
    @(negedge clk);
    chk("empty_read", bus.adcfifo_readdata, 0);
    // 16-bit samples, 3.125 MHz BCLK
    slot(1, 4, 64'h5);
    frame(64'hA5C3, 64'h3C5A, 16);
    settle();
    chk("lvl1", bus.fifo_level, 1);
    rd_lit("w16", 32'hA5C33C5A);
    chk("empty_after", bus.adcfifo_empty, 1);
    // 32-bit slots keep only the upper 16 bits
    frame(64'h1234_FFFF, 64'h8001_0000, 32);
    settle();
    rd_lit("w32", 32'h1234_8001);
    // start mid-right-slot after a reset
    reset_n = 0;
    rst_model();
    repeat (3) @(negedge clk);
    reset_n = 1;
    slot(1, 7, 64'h55);
    frame(64'h1, 64'h2, 16);
    frame(64'h3, 64'h4, 16);
    settle();
    rd_lit("mid_a", 32'h0001_0002);
    rd_lit("mid_b", 32'h0003_0004);
    // overflow with 6 frames
    for (int k = 1; k <= 6; k++) frame(64'(k), 64'(k), 16);
    settle();
    chk("full_lvl", bus.fifo_level, 4);
    chk("ovf_set", bus.overflow, 1);
    for (int k = 1; k <= 4; k++) rd_lit("ovf_word", {16'(k), 16'(k)});
    chk("ovf_sticky", bus.overflow, 1);
    // reset mid-left-slot with 2 words buffered
    frame(64'h1, 64'h1, 16);
    frame(64'h2, 64'h2, 16);
    settle();
    chk("pre_rst_lvl", bus.fifo_level, 2);
    quiet = 0;
    for (int i = 0; i < 9; i++) bit_(0, 1'($urandom));
    reset_n = 0;
    #1;
    chk("mid_rst_empty", bus.adcfifo_empty, 1);
    chk("mid_rst_lvl", bus.fifo_level, 0);
    rst_model();
    repeat (3) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 8; i++) bit_(0, 1'($urandom));
    slot(1, 16, 64'h9999);
    frame(64'h7, 64'h8, 16);
    settle();
    rd_lit("post_rst", 32'h0007_0008);
    // randomized frames, timing and slot lengths
    for (int it = 0; it < 10; it++) begin
      int nf, nd;
      lo = $urandom_range(2, 6);
      hi = $urandom_range(2, 6);
      nf = $urandom_range(1, 4);
      for (int f = 0; f < nf; f++) begin
        int nl, nr;
        nl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, CH - 1) : CH + $urandom_range(0, 8);
        nr = ($urandom_range(0, 4) == 0) ? $urandom_range(1, CH - 1) : CH + $urandom_range(0, 8);
        slot(0, nl, {$urandom, $urandom});
        slot(1, nr, {$urandom, $urandom});
      end
      settle();
      nd = $urandom_range(0, q.size() + 1);
      for (int i = 0; i < nd; i++) rd(w);
    end
    while (q.size() > 0) rd(w);
    rd(w);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/i2s_rx_oversampled.md
Name: i2s_rx_oversampled

Overview:
- Single-clock I2S capture stage feeding the audio effect chain (reverb/chorus/distortion) in the loopback path.
- Oversamples the codec BCLK/ADCLRC/ADCDAT pins in the system clk domain and deserialises left/right samples into one packed stereo word.
- Buffers packed words in a small FIFO and exposes the read/empty interface the loopback top already uses.
- Removes the dual-clock FIFO from the receive path.

Parameters:
- DATA_WIDTH, 32, packed stereo word width; channel width CH_W = DATA_WIDTH/2; must be even.
- FIFO_DEPTH, 4, word buffer depth; power of two, 2 or more.
- SYNC_STAGES, 2, synchroniser flops per input pin; 2 or more.

Ports:
- clk  in  1  system clock; frequency at least 4x BCLK.
- reset_n  in  1  reset, asynchronous, active-low.
- bclk  in  1  I2S bit clock pin; asynchronous to clk.
- adclrc  in  1  I2S word select; 0 = left, 1 = right.
- adcdat  in  1  I2S serial data, MSB first.
- adcfifo_read  in  1  read request.
- adcfifo_empty  out  1  FIFO empty, registered.
- adcfifo_readdata  out  DATA_WIDTH  {left[CH_W-1:0], right[CH_W-1:0]}; left occupies the upper half.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky drop flag.

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: adcfifo_empty=1, adcfifo_readdata=0, fifo_level=0, overflow=0. Reset also clears the shifter, pointers and frame state.
- Input sync:
  - bclk, adclrc and adcdat each pass through SYNC_STAGES flops, plus one flop on bclk for edge detect.
  - A bclk rise is a one-clk pulse when the synced bclk is 1 and the delayed bclk is 0.
  - All bit sampling happens only on rise pulses; pin-to-sample latency is SYNC_STAGES+1 clk.
  - BCLK high and low phases must each be at least 2 clk; otherwise behaviour is undefined.
- Slot framing, evaluated on each rise pulse; lrc_last holds the LRC value from the previous rise.
  - When LRC differs from lrc_last: slot start. Set bit_cnt=0, set ch=LRC, discard any partial shift. No data is captured on this edge (I2S one-bit delay).
  - Otherwise, when bit_cnt<CH_W: shift = {shift[CH_W-2:0], dat} and increment bit_cnt.
  - When bit_cnt reaches CH_W, the channel is complete.
  - Bits beyond CH_W in the slot (e.g. 32-bit slots with CH_W=16) are ignored.
- Word assembly:
  - A complete left channel loads left_hold and sets left_ok.
  - A complete right channel with left_ok=1 raises push for exactly one clk with {left_hold, shift}, then clears left_ok.
  - A complete right channel with left_ok=0 is discarded. This covers the first frame after reset or after a truncated left slot.
  - A slot that ends early (LRC toggles before CH_W bits) discards the partial word; for a left slot it also clears left_ok.
- FIFO:
  - Pointers are clog2(FIFO_DEPTH)+1 bits wide; full and empty come from pointer compare.
  - Write happens on push when not full.
  - Push while full drops the word and sets overflow=1 until reset. Full is evaluated on pre-read state, so push+read in the same cycle while full still drops.
  - Read happens on adcfifo_read when not empty. adcfifo_readdata updates on the next clk edge (1-cycle latency) and holds until the next accepted read.
  - Read while empty is ignored; readdata and pointers are unchanged.
  - Push and read in the same cycle with 0<level<FIFO_DEPTH: level unchanged, both operations performed.
  - Push into an empty FIFO: empty deasserts the next clk. A read in that same cycle is ignored.
  - adcfifo_empty and fifo_level are registered and reflect state after the clk edge.
- Reset mid-frame: the partial word is lost and buffered words are lost. Capture resumes at the next LRC transition; the first pushed word requires a complete left slot followed by a complete right slot.
- Pointer wrap-around is natural modulo 2*FIFO_DEPTH; there is no special case.

Test Plan:
- Reset hold 10 clk, then release with bclk idle -> empty=1, readdata=0, level=0, overflow=0.
- Codec model (clk=50 MHz, BCLK=3.125 MHz, 16-bit slots) sends L=16'hA5C3, R=16'h3C5A. Pulse read when empty=0 -> readdata=32'hA5C33C5A one clk after read; empty=1 again.
- 32-bit slots with L=32'h1234_FFFF and R=32'h8001_0000 -> word 32'h1234_8001 (low 16 bits per slot ignored).
- Start stimulus mid-right-slot after reset, then frames (1,2) and (3,4) -> the first partial right slot is discarded; words read are 32'h00010002, then 32'h00030004.
- Send 6 frames with read held low, FIFO_DEPTH=4 -> level=4; overflow=1 after the 5th push and stays 1; reads return frames 1-4 in order; 5 and 6 are lost.
- Assert reset mid-left-slot while 2 words are buffered -> empty=1 and level=0 immediately. The next complete frame (7,8) yields 32'h00070008 as the first word.
